// File: rtl/ga_pkg.sv
// Shared constants and VSYNC state encoding for the Gate Array sync/interrupt unit.
package ga_pkg;

  localparam int unsigned GA_INT_LINES = 52;
  localparam int unsigned GA_R52_MSB   = 32;
  localparam int unsigned GA_HS_DELAY  = 2;
  localparam int unsigned GA_HS_MAX    = 4;
  localparam int unsigned GA_VS_DELAY  = 2;
  localparam int unsigned GA_VS_LINES  = 4;

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_WAIT,
    VS_ACTIVE
  } vs_state_t;

endpackage

// File: rtl/ga_sync_edge.sv
// Character-rate rise/fall detector for one CRTC sync line.
module ga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clken,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_d <= 1'b0;
    end else if (clken) begin
      sig_d <= sig;
    end
  end

  // Edges are only meaningful on the tick that samples them.
  assign rise = clken & sig & ~sig_d;
  assign fall = clken & ~sig & sig_d;

endmodule

// File: rtl/ga_sync_int.sv
// Gate Array sync shaping (monitor HSYNC/VSYNC) and R52 line-counter interrupt.
module ga_sync_int
  import ga_pkg::*;
#(
  parameter int unsigned HS_DELAY  = GA_HS_DELAY,
  parameter int unsigned HS_MAX    = GA_HS_MAX,
  parameter int unsigned VS_DELAY  = GA_VS_DELAY,
  parameter int unsigned VS_LINES  = GA_VS_LINES,
  parameter int unsigned INT_LINES = GA_INT_LINES
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       crtc_hsync,
  input  logic       crtc_vsync,
  input  logic       int_ack,
  input  logic       r52_clear,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       INT,
  output logic [5:0] r52
);

  localparam logic [2:0] HS_ON   = 3'(HS_DELAY);
  localparam logic [2:0] HS_OFF  = 3'(HS_DELAY + HS_MAX);
  localparam logic [2:0] VD_INIT = 3'(VS_DELAY);
  localparam logic [2:0] VL_INIT = 3'(VS_LINES);
  localparam logic [5:0] INT_TC  = 6'(INT_LINES);
  localparam logic [5:0] R52_MSB = 6'(GA_R52_MSB);

  logic       hs_rise, hs_fall;
  logic       vs_rise, vs_fall_unused;
  logic [2:0] hcnt;
  logic [2:0] vdly, vlen;
  vs_state_t  vs_state;
  logic       resync;
  logic [5:0] r52_inc, r52_next;
  logic       int_raise, int_next;

  ga_sync_edge u_hs_edge (
    .clk   (CLOCK),
    .rst_n (nRESET),
    .clken (CLKEN),
    .sig   (crtc_hsync),
    .rise  (hs_rise),
    .fall  (hs_fall)
  );

  ga_sync_edge u_vs_edge (
    .clk   (CLOCK),
    .rst_n (nRESET),
    .clken (CLKEN),
    .sig   (crtc_vsync),
    .rise  (vs_rise),
    .fall  (vs_fall_unused)
  );

  // HSYNC: delayed start, width capped; a low CRTC HSYNC always ends the pulse.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      hcnt      <= '0;
      hsync_out <= 1'b0;
    end else if (CLKEN) begin
      if (!crtc_hsync) begin
        hcnt      <= '0;
        hsync_out <= 1'b0;
      end else if (hs_rise) begin
        hcnt <= 3'd1;
      end else begin
        if (hcnt != 3'd7) begin
          hcnt <= hcnt + 3'd1;
        end
        if (hcnt == HS_ON) begin
          hsync_out <= 1'b1;
        end else if (hcnt == HS_OFF) begin
          hsync_out <= 1'b0;
        end
      end
    end
  end

  // The hs_fall that empties the delay counter is the R52 resync point.
  assign resync = (vs_state == VS_WAIT) && hs_fall && (vdly <= 3'd1);

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      vs_state  <= VS_IDLE;
      vdly      <= '0;
      vlen      <= '0;
      vsync_out <= 1'b0;
    end else begin
      case (vs_state)
        VS_IDLE: begin
          if (vs_rise) begin
            vdly     <= VD_INIT;
            vs_state <= VS_WAIT;
          end
        end
        VS_WAIT: begin
          if (resync) begin
            vdly      <= '0;
            vlen      <= VL_INIT;
            vsync_out <= 1'b1;
            vs_state  <= VS_ACTIVE;
          end else if (hs_fall) begin
            vdly <= vdly - 3'd1;
          end
        end
        VS_ACTIVE: begin
          if (hs_fall) begin
            if (vlen <= 3'd1) begin
              vlen      <= '0;
              vsync_out <= 1'b0;
              vs_state  <= VS_IDLE;
            end else begin
              vlen <= vlen - 3'd1;
            end
          end
        end
        default: begin
          vs_state  <= VS_IDLE;
          vsync_out <= 1'b0;
        end
      endcase
    end
  end

  // Priority, lowest to highest: line count, resync, int_ack, r52_clear.
  // A raise in the same cycle as int_ack survives; the MSB clear hits the new count.
  always_comb begin
    r52_inc   = r52 + 6'd1;
    r52_next  = r52;
    int_raise = 1'b0;
    if (hs_fall) begin
      if (r52_inc == INT_TC) begin
        r52_next  = '0;
        int_raise = 1'b1;
      end else begin
        r52_next = r52_inc;
      end
      if (resync) begin
        r52_next = '0;
        if ((r52_inc & R52_MSB) != '0) begin
          int_raise = 1'b1;
        end
      end
    end
    if (int_ack) begin
      r52_next = r52_next & ~R52_MSB;
    end
    int_next = int_raise | (INT & ~int_ack);
    if (r52_clear) begin
      r52_next = '0;
      int_next = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      r52 <= '0;
      INT <= 1'b0;
    end else begin
      r52 <= r52_next;
      INT <= int_next;
    end
  end

endmodule

// File: tb/tb_ga_sync_int.sv
// Self-checking bench for ga_sync_int: HSYNC shaping, R52/INT, VSYNC resync, reset.
module tb_ga_sync_int;

  localparam int unsigned HS_DELAY = 2;
  localparam int unsigned HS_MAX   = 4;

  typedef struct {
    logic       intr;
    logic [5:0] cnt;
    logic       vs;
  } exp_t;

  logic       CLOCK = 1'b0;
  logic       nRESET = 1'b0;
  logic       CLKEN = 1'b0;
  logic       crtc_hsync = 1'b0;
  logic       crtc_vsync = 1'b0;
  logic       int_ack = 1'b0;
  logic       r52_clear = 1'b0;
  logic       hsync_out, vsync_out, INT;
  logic [5:0] r52;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic hs_q[$];

  ga_sync_int #(
    .HS_DELAY  (2),
    .HS_MAX    (4),
    .VS_DELAY  (2),
    .VS_LINES  (4),
    .INT_LINES (52)
  ) dut (
    .CLOCK      (CLOCK),
    .nRESET     (nRESET),
    .CLKEN      (CLKEN),
    .crtc_hsync (crtc_hsync),
    .crtc_vsync (crtc_vsync),
    .int_ack    (int_ack),
    .r52_clear  (r52_clear),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .INT        (INT),
    .r52        (r52)
  );

  always #5 CLOCK = ~CLOCK;

  // One character tick: inputs and CLKEN held across exactly one rising edge.
  task automatic tick(input logic hs, input logic vs, input logic ack, input logic clr);
    @(negedge CLOCK);
    crtc_hsync = hs;
    crtc_vsync = vs;
    int_ack    = ack;
    r52_clear  = clr;
    CLKEN      = 1'b1;
    @(negedge CLOCK);
    CLKEN     = 1'b0;
    int_ack   = 1'b0;
    r52_clear = 1'b0;
  endtask

  task automatic pulse(input logic ack, input logic clr);
    @(negedge CLOCK);
    int_ack   = ack;
    r52_clear = clr;
    @(negedge CLOCK);
    int_ack   = 1'b0;
    r52_clear = 1'b0;
  endtask

  // One scan line: 4 ticks HSYNC high, then 4 low; strobes land on the fall tick.
  task automatic hs_line(input logic vs, input logic ack, input logic clr);
    repeat (4) tick(1'b1, vs, 1'b0, 1'b0);
    tick(1'b0, vs, ack, clr);
    repeat (3) tick(1'b0, vs, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    nRESET = 1'b0;
    CLKEN = 1'b0;
    crtc_hsync = 1'b0;
    crtc_vsync = 1'b0;
    int_ack = 1'b0;
    r52_clear = 1'b0;
    repeat (2) @(negedge CLOCK);
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (hsync_out !== 1'b0 || vsync_out !== 1'b0 || INT !== 1'b0 || r52 !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: hs=%b vs=%b INT=%b r52=%0d, expected all 0",
               hsync_out, vsync_out, INT, r52);
    end
  endtask

  task automatic test_hsync(input int width, input int exp_len);
    int   n_hi;
    logic e;
    n_hi = 0;
    do_reset();
    for (int k = 0; k < width + 3; k++) begin
      hs_q.push_back((k >= int'(HS_DELAY)) && (k < int'(HS_DELAY + HS_MAX)) && (k < width));
      tick(k < width, 1'b0, 1'b0, 1'b0);
      e = hs_q.pop_front();
      checks++;
      if (hsync_out !== e) begin
        errors++;
        $display("FAIL hsync_w%0d_t%0d: hsync_out=%b, expected %b", width, k, hsync_out, e);
      end
      if (hsync_out === 1'b1) n_hi++;
    end
    checks++;
    if (n_hi != exp_len) begin
      errors++;
      $display("FAIL hsync_len_w%0d: %0d ticks, expected %0d", width, n_hi, exp_len);
    end
  endtask

  task automatic test_free_int();
    int unsigned cnt;
    int          n_int;
    exp_t        e;
    cnt = 0;
    n_int = 0;
    do_reset();
    for (int i = 1; i <= 312; i++) begin
      cnt = (cnt + 1) % 52;
      e.intr = (cnt == 0);
      e.cnt  = 6'(cnt);
      e.vs   = 1'b0;
      exp_q.push_back(e);
      hs_line(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (INT !== e.intr || r52 !== e.cnt) begin
        errors++;
        $display("FAIL free_line%0d: INT=%b r52=%0d, expected INT=%b r52=%0d",
                 i, INT, r52, e.intr, e.cnt);
      end
      if (INT === 1'b1) n_int++;
      if (e.intr) begin
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (INT !== 1'b1) begin
          errors++;
          $display("FAIL free_hold%0d: INT=%b, expected 1", i, INT);
        end
        pulse(1'b1, 1'b0);
        checks++;
        if (INT !== 1'b0) begin
          errors++;
          $display("FAIL free_ack%0d: INT=%b, expected 0", i, INT);
        end
      end
    end
    checks++;
    if (n_int != 6) begin
      errors++;
      $display("FAIL free_int_count: %0d, expected 6", n_int);
    end
  endtask

  task automatic test_vsync_resync(input int start, input logic exp_int);
    exp_t e;
    do_reset();
    repeat (start) hs_line(1'b0, 1'b0, 1'b0);
    e.intr = 1'b0; e.cnt = 6'(start + 1); e.vs = 1'b0;
    exp_q.push_back(e);
    e.intr = exp_int; e.cnt = 6'd0; e.vs = 1'b1;
    exp_q.push_back(e);
    // CRTC VSYNC drops after two vsync_out lines; vsync_out must still last 4 falls.
    for (int j = 1; j <= 4; j++) begin
      e.intr = exp_int; e.cnt = 6'(j); e.vs = (j < 4);
      exp_q.push_back(e);
    end
    for (int j = 0; j < 6; j++) begin
      hs_line(j < 4, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (vsync_out !== e.vs || INT !== e.intr || r52 !== e.cnt) begin
        errors++;
        $display("FAIL vsync_r%0d_l%0d: vs=%b INT=%b r52=%0d, expected vs=%b INT=%b r52=%0d",
                 start, j, vsync_out, INT, r52, e.vs, e.intr, e.cnt);
      end
    end
  endtask

  task automatic test_int_ack();
    exp_t e;
    do_reset();
    repeat (52 + 37) hs_line(1'b0, 1'b0, 1'b0);
    checks++;
    if (INT !== 1'b1 || r52 !== 6'd37) begin
      errors++;
      $display("FAIL ack_pre: INT=%b r52=%0d, expected INT=1 r52=37", INT, r52);
    end
    e.intr = 1'b0; e.cnt = 6'd5; e.vs = 1'b0;
    exp_q.push_back(e);
    pulse(1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (INT !== e.intr || r52 !== e.cnt) begin
      errors++;
      $display("FAIL ack_r37: INT=%b r52=%0d, expected INT=%b r52=%0d", INT, r52, e.intr, e.cnt);
    end
    repeat (46) hs_line(1'b0, 1'b0, 1'b0);
    e.intr = 1'b1; e.cnt = 6'd0; e.vs = 1'b0;
    exp_q.push_back(e);
    hs_line(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (INT !== e.intr || r52 !== e.cnt) begin
      errors++;
      $display("FAIL ack_vs_raise: INT=%b r52=%0d, expected INT=%b r52=%0d", INT, r52, e.intr, e.cnt);
    end
  endtask

  task automatic test_r52_clear();
    exp_t e;
    do_reset();
    repeat (51) hs_line(1'b0, 1'b0, 1'b0);
    checks++;
    if (r52 !== 6'd51 || INT !== 1'b0) begin
      errors++;
      $display("FAIL clear_pre: INT=%b r52=%0d, expected INT=0 r52=51", INT, r52);
    end
    e.intr = 1'b0; e.cnt = 6'd0; e.vs = 1'b0;
    exp_q.push_back(e);
    hs_line(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (INT !== e.intr || r52 !== e.cnt) begin
      errors++;
      $display("FAIL clear_vs_raise: INT=%b r52=%0d, expected INT=%b r52=%0d", INT, r52, e.intr, e.cnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    repeat (40) hs_line(1'b0, 1'b0, 1'b0);
    repeat (2) hs_line(1'b1, 1'b0, 1'b0);
    checks++;
    if (vsync_out !== 1'b1 || INT !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: vs=%b INT=%b, expected vs=1 INT=1", vsync_out, INT);
    end
    @(negedge CLOCK);
    #2;
    nRESET = 1'b0;
    crtc_vsync = 1'b1;
    #1;
    checks++;
    if (hsync_out !== 1'b0 || vsync_out !== 1'b0 || INT !== 1'b0 || r52 !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_async: hs=%b vs=%b INT=%b r52=%0d, expected all 0",
               hsync_out, vsync_out, INT, r52);
    end
    repeat (2) @(negedge CLOCK);
    nRESET = 1'b1;
    e.intr = 1'b0; e.cnt = 6'd1; e.vs = 1'b0;
    exp_q.push_back(e);
    e.intr = 1'b0; e.cnt = 6'd0; e.vs = 1'b1;
    exp_q.push_back(e);
    for (int j = 0; j < 2; j++) begin
      hs_line(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (vsync_out !== e.vs || INT !== e.intr || r52 !== e.cnt) begin
        errors++;
        $display("FAIL rstmid_restart_l%0d: vs=%b INT=%b r52=%0d, expected vs=%b INT=%b r52=%0d",
                 j, vsync_out, INT, r52, e.vs, e.intr, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync(14, 4);
    test_hsync(3, 1);
    test_hsync(2, 0);
    test_free_int();
    test_vsync_resync(40, 1'b1);
    test_vsync_resync(20, 1'b0);
    test_int_ack();
    test_r52_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
